// File: rtl/hash_sched_if.sv
// Request/response bundle between hash clients, consumer and the shared hash scheduler.
interface hash_sched_if #(
    parameter int N_REQ     = 2,
    parameter int D_SIZE    = 32,
    parameter int HASH_SIZE = 10
);
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*D_SIZE-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [IDW-1:0]          rsp_id;
    logic [HASH_SIZE-1:0]    rsp_hash;
    logic                    busy;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_hash, busy
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_hash, busy
    );
endinterface

// File: rtl/hash_sched.sv
// Round-robin scheduler sharing one iterative 5-bit-chunk hash engine
// among N_REQ requesters; one tagged result per accepted request.
module hash_sched #(
    parameter int N_REQ     = 2,
    parameter int D_SIZE    = 32,
    parameter int HASH_SIZE = 10
) (
    input logic        clk,
    input logic        rst,
    hash_sched_if.slave bus
);
    localparam int NCHUNK = D_SIZE / 5;
    localparam int LW     = NCHUNK * 5;
    localparam int IDW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, HASH, RESP} state_t;

    state_t               state, state_nxt;
    logic [LW-1:0]        data_q;
    logic [IDW-1:0]       cur_id;
    logic [IDW-1:0]       last_grant;
    logic [HASH_SIZE-1:0] acc;
    logic [CW-1:0]        cnt;
    logic [IDW-1:0]       rsp_id_q;
    logic [HASH_SIZE-1:0] rsp_hash_q;

    logic [N_REQ-1:0]     grant;
    logic [IDW-1:0]       gid;
    logic                 found;
    logic                 hs;
    logic                 last_chunk;
    logic [4:0]           chunk;
    logic [HASH_SIZE-1:0] mix;
    logic [HASH_SIZE-1:0] acc_nxt;

    // Search starts one past the previous winner so priority rotates.
    always_comb begin
        grant = '0;
        gid   = '0;
        found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!found && bus.req_valid[(int'(last_grant) + i) % N_REQ]) begin
                grant[(int'(last_grant) + i) % N_REQ] = 1'b1;
                gid   = IDW'((int'(last_grant) + i) % N_REQ);
                found = 1'b1;
            end
        end
    end

    assign hs         = (state == IDLE) && found;
    assign last_chunk = (cnt == CW'(NCHUNK - 1));
    assign chunk      = data_q[int'(cnt)*5 +: 5];
    assign mix        = acc ^ HASH_SIZE'(chunk);
    // x*17 as shift-add, truncated to the accumulator width
    assign acc_nxt    = mix + (mix << 4);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (hs) state_nxt = HASH;
            HASH: if (last_chunk) state_nxt = RESP;
            RESP: if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            data_q     <= '0;
            cur_id     <= '0;
            last_grant <= IDW'(N_REQ - 1);
            acc        <= '0;
            cnt        <= '0;
            rsp_id_q   <= '0;
            rsp_hash_q <= '0;
        end else begin
            state <= state_nxt;
            if (hs) begin
                data_q     <= bus.req_data[int'(gid)*D_SIZE +: LW];
                cur_id     <= gid;
                last_grant <= gid;
                acc        <= HASH_SIZE'(31);
                cnt        <= '0;
            end
            if (state == HASH) begin
                acc <= acc_nxt;
                cnt <= cnt + 1'b1;
                if (last_chunk) begin
                    rsp_hash_q <= acc_nxt;
                    rsp_id_q   <= cur_id;
                end
            end
        end
    end

    assign bus.req_ready = (state == IDLE) ? grant : '0;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_hash  = rsp_hash_q;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_hash_sched.sv
// Self-checking bench for hash_sched: vector table, random traffic
// against an arithmetic hash model, and multi-cycle corner sequences.
module tb_hash_sched;
    localparam int N_REQ     = 2;
    localparam int D_SIZE    = 32;
    localparam int HASH_SIZE = 10;
    localparam int NCHUNK    = D_SIZE / 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    hash_sched_if #(.N_REQ(N_REQ), .D_SIZE(D_SIZE), .HASH_SIZE(HASH_SIZE)) bus ();

    hash_sched #(.N_REQ(N_REQ), .D_SIZE(D_SIZE), .HASH_SIZE(HASH_SIZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          id;
        logic [31:0] data;
        logic [9:0]  exp;
    } vec_t;

    vec_t vecs[4];

    function automatic logic [9:0] model(input logic [31:0] d);
        int h;
        int c;
        h = 31;
        for (int i = 0; i < NCHUNK; i++) begin
            c = int'((d >> (5 * i)) & 32'h1f);
            h = ((h ^ c) * 17) % 1024;
        end
        return h[9:0];
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset rsp_valid", bus.rsp_valid, 0);
        check("reset busy", bus.busy, 0);
        check("reset req_ready", bus.req_ready, 0);
        check("reset rsp_id", bus.rsp_id, 0);
        check("reset rsp_hash", bus.rsp_hash, 0);
    endtask

    task automatic run_one(input int id, input logic [31:0] d,
                           input logic [9:0] exp, input string nm);
        int n;
        logic [N_REQ-1:0] oh;
        @(negedge clk);
        bus.req_data[id*D_SIZE +: D_SIZE] = d;
        bus.req_valid[id] = 1'b1;
        #1;
        n = 0;
        while (!bus.req_ready[id] && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        oh = N_REQ'(1) << id;
        check({nm, " grant"}, bus.req_ready, oh);
        @(posedge clk);
        #1 bus.req_valid[id] = 1'b0;
        n = 0;
        while (!bus.rsp_valid && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({nm, " latency"}, 1 + n, NCHUNK + 1);
        check({nm, " hash"}, bus.rsp_hash, exp);
        check({nm, " id"}, bus.rsp_id, id);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        check({nm, " back to idle"}, {bus.rsp_valid, bus.busy}, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int bad;
        int id;
        logic [31:0] d0, d1;
        logic [9:0]  h0;
        int gq[$];
        int gc[$];
        int rq[$];
        logic [9:0] hq[$];

        vecs[0] = '{0, 32'h0000_0000, 10'h0BF};
        vecs[1] = '{1, 32'hFFFF_FFFF, 10'h1EF};
        vecs[2] = '{1, 32'h3FFF_FFFF, 10'h1EF};
        vecs[3] = '{0, 32'h0000_001F, 10'h000};

        bus.req_data = '0;
        do_reset();

        foreach (vecs[i])
            run_one(vecs[i].id, vecs[i].data, vecs[i].exp, $sformatf("vec%0d", i));

        for (int i = 0; i < 24; i++) begin
            id = int'($urandom_range(0, N_REQ - 1));
            d0 = $urandom;
            run_one(id, d0, model(d0), $sformatf("rand%0d", i));
        end

        // Round-robin with both requesters always valid
        do_reset();
        d0 = $urandom;
        d1 = $urandom;
        bus.req_data  = {d1, d0};
        bus.req_valid = 2'b11;
        bus.rsp_ready = 1'b1;
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if ($countones(bus.req_ready) > 1) bad++;
            if (bus.req_ready != 0) begin
                gq.push_back(bus.req_ready[1] ? 1 : 0);
                gc.push_back(c);
            end
            if (bus.rsp_valid) begin
                rq.push_back(int'(bus.rsp_id));
                hq.push_back(bus.rsp_hash);
            end
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        check("rr two-hot", bad, 0);
        check("rr grant count", gq.size() >= 4, 1);
        check("rr rsp count", rq.size() >= 4, 1);
        if (gq.size() >= 4 && rq.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("rr grant%0d", i), gq[i], i % 2);
                check($sformatf("rr rsp_id%0d", i), rq[i], i % 2);
                check($sformatf("rr hash%0d", i), hq[i], model((i % 2) ? d1 : d0));
            end
            check("rr period", gc[1] - gc[0], NCHUNK + 2);
        end

        // Backpressure in RESP
        do_reset();
        d0 = $urandom;
        d1 = $urandom;
        bus.req_data  = {d1, d0};
        bus.req_valid = 2'b11;
        n = 0;
        @(negedge clk);
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp rsp_valid", bus.rsp_valid, 1);
        check("bp id", bus.rsp_id, 0);
        check("bp hash", bus.rsp_hash, model(d0));
        h0  = bus.rsp_hash;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!bus.rsp_valid || bus.rsp_hash !== h0 || bus.req_ready != 0 || !bus.busy)
                bad++;
        end
        check("bp hold", bad, 0);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        check("bp release valid", bus.rsp_valid, 0);
        check("bp release busy", bus.busy, 0);
        check("bp next grant", bus.req_ready, 2'b10);
        bus.req_valid = '0;

        // Reset during HASH with cnt == 3
        do_reset();
        d0 = $urandom;
        @(negedge clk);
        bus.req_data[0 +: D_SIZE] = d0;
        bus.req_valid[0] = 1'b1;
        #1 check("abort grant", bus.req_ready, 2'b01);
        @(posedge clk);
        #1 bus.req_valid = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("abort busy", bus.busy, 0);
        check("abort rsp_valid", bus.rsp_valid, 0);
        check("abort req_ready", bus.req_ready, 0);
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) bad++;
        end
        check("abort no response", bad, 0);
        bus.req_valid = 2'b11;
        #1 check("abort first priority", bus.req_ready, 2'b01);
        bus.req_valid = '0;
        d1 = $urandom;
        run_one(0, d1, model(d1), "post-abort");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hash_sched.md
Name: hash_sched

Overview:
- Round-robin scheduler that shares one iterative hash engine among N_REQ requesters.
- Each accepted request is hashed one 5-bit chunk per cycle using the team hash function:
  - h starts at 31.
  - For each chunk i: h = (h ^ chunk_i) * 17, truncated to HASH_SIZE.
- One result is returned per request on a single valid/ready response port, tagged with the requester index.
- Sits between multiple lookup/insert clients and the bloom-filter bit array, so one hash datapath serves all clients.

Parameters:
- N_REQ, 2, number of requesters (>=2).
- D_SIZE, 32, request data width in bits.
- HASH_SIZE, 10, hash output width (>=5).
- Derived, not overridable: NCHUNK = D_SIZE/5 (floor). IDW = max(1, $clog2(N_REQ)).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- req_valid  input  N_REQ  per-requester request valid.
- req_data  input  N_REQ*D_SIZE  requester k data at bits [k*D_SIZE +: D_SIZE].
- req_ready  output  N_REQ  one-hot grant; a handshake occurs where valid & ready.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  IDW  index of the requester that owns the result.
- rsp_hash  output  HASH_SIZE  hash result.
- busy  output  1  high in HASH and RESP states.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; all state updates on the rising edge of clk.
- Reset values: state=IDLE, rsp_valid=0, rsp_id=0, rsp_hash=0, busy=0, req_ready=0, chunk counter=0, last_grant=N_REQ-1 (so requester 0 has first priority).
- FSM states: IDLE, HASH, RESP.
- IDLE:
  - req_ready is combinational: one-hot on the first asserted req_valid, searching from (last_grant+1) mod N_REQ upward with wrap.
  - req_ready is all-zero if no req_valid is asserted.
  - On handshake: latch data and id, set last_grant=id, acc=31 (zero-extended to HASH_SIZE), cnt=0, go to HASH.
- HASH:
  - Each cycle: acc <= ((acc ^ zext(chunk[cnt])) * 17) mod 2^HASH_SIZE, where chunk[cnt] = data[cnt*5 +: 5] and cnt increments.
  - Multiply may be implemented as acc + (acc<<4) truncated.
  - On the cycle cnt == NCHUNK-1: perform the final update, go to RESP.
  - Data bits at index >= NCHUNK*5 are ignored.
- RESP:
  - rsp_valid=1; rsp_hash and rsp_id hold stable until rsp_ready.
  - On rsp_valid & rsp_ready: rsp_valid=0 next cycle, go to IDLE.
- Outputs outside IDLE: req_ready=0 in HASH and RESP.
- Latency: handshake in cycle T -> rsp_valid first high in cycle T+NCHUNK+1 (T+7 at defaults).
- Throughput: with rsp_ready held high, the next grant can occur in the cycle after the response handshake. Minimum request period is NCHUNK+2 cycles.
- Backpressure: rsp_ready low holds RESP indefinitely. No new requests are accepted and no state changes.
- Simultaneous requests: resolved strictly round-robin. A requester that keeps req_valid high is served within N_REQ grants.
- Requester obligations: a requester must hold req_valid and req_data stable until its req_ready. The scheduler does not buffer ungranted requests.
- Reset mid-operation: an in-flight hash or pending response is discarded and all reset values are restored on the next edge. No response is emitted for the aborted request.
- rsp_hash and rsp_id retain the last delivered value after returning to IDLE; only rsp_valid qualifies them.

Test Plan:
- Reset, then req_valid[0]=1 with req_data[0]=32'h00000000 -> req_ready[0]=1 the same cycle; rsp_valid rises 7 cycles later with rsp_hash=10'h0BF, rsp_id=0.
- req_data[1]=32'hFFFFFFFF on requester 1 only -> rsp_hash=10'h1EF, rsp_id=1. Top 2 bits are ignored: 32'h3FFFFFFF gives the same result.
- req_data[0]=32'h0000001F -> rsp_hash=10'h000.
- Both req_valid high continuously from reset -> grants in order 0,1,0,1; rsp_id sequence 0,1,0,1; req_ready never two-hot.
- rsp_ready held low for 20 cycles in RESP with both requesters valid -> rsp_valid stays 1, rsp_hash stays stable, req_ready stays 0, busy=1. Raising rsp_ready -> IDLE next cycle, then the other requester is granted.
- Assert rst for one cycle during HASH (cnt=3) -> next cycle state=IDLE, busy=0, rsp_valid=0, no response for the aborted request. A following request from requester 0 is granted first and hashes correctly.
